// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces whole 16-key snapshots and reports clean single-key presses.
//
// Output protocol: key_valid is a one-cycle strobe with no back-pressure
// (there is no ready). key_code is updated on the same edge that raises
// key_valid and holds otherwise; key_down is a level that tracks whether the
// debounced snapshot has any key pressed.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    // Column synchronizer
    logic [3:0] col_m;
    logic [3:0] col_s;

    // Row scan timing
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [1:0]       row_idx_next;
    logic             sample_now;

    // Snapshot assembly and debounce
    logic [15:0]      cur_snap;
    logic             snap_done;
    logic [15:0]      prev_snap;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      debounced;

    // Event decode
    logic       accept;
    logic       single_key;
    logic       press_event;
    logic [3:0] hot_idx;

    // Two-flop synchronizer; the keypad columns idle high (pulled up).
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    // A row is sampled on the last cycle of its dwell period, giving the
    // row lines and the synchronizer time to settle after the row switch.
    always_comb begin
        sample_now   = (div == DIV_LAST);
        row_idx_next = row_idx + 2'd1;
    end

    // Dwell counter and row selection; row is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            row_idx <= 2'd0;
            row     <= 4'b1110;
        end else if (sample_now) begin
            div     <= '0;
            row_idx <= row_idx_next;
            row     <= ~(4'b0001 << row_idx_next);
        end else begin
            div <= div + 1'b1;
        end
    end

    // Capture the active row's columns into the snapshot; flag the scan
    // complete after row 3 so the full snapshot is judged on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_snap  <= 16'h0000;
            snap_done <= 1'b0;
        end else begin
            snap_done <= sample_now && (row_idx == 2'd3);
            if (sample_now) begin
                case (row_idx)
                    2'd0:    cur_snap[3:0]   <= ~col_s;
                    2'd1:    cur_snap[7:4]   <= ~col_s;
                    2'd2:    cur_snap[11:8]  <= ~col_s;
                    default: cur_snap[15:12] <= ~col_s;
                endcase
            end
        end
    end

    // Debounce decision: count consecutive identical snapshots and accept
    // once the count reaches its saturation value.
    always_comb begin
        cnt_next = '0;
        if (cur_snap == prev_snap) begin
            cnt_next = (stable_cnt == CNT_LAST) ? CNT_LAST : stable_cnt + 1'b1;
        end
        accept = snap_done && (cnt_next == CNT_LAST);
    end

    // A press event is a transition out of the all-released state into a
    // snapshot with exactly one key; rollover and chords never qualify.
    always_comb begin
        single_key  = (cur_snap != 16'h0000) &&
                      ((cur_snap & (cur_snap - 16'd1)) == 16'h0000);
        press_event = accept && (cur_snap != debounced) &&
                      (debounced == 16'h0000) && single_key;
    end

    // Encode the key index; only meaningful when exactly one bit is set.
    always_comb begin
        hot_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cur_snap[i]) begin
                hot_idx = 4'(i);
            end
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_snap  <= 16'h0000;
            stable_cnt <= '0;
            debounced  <= 16'h0000;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
            key_down   <= 1'b0;
        end else begin
            key_valid <= press_event;
            if (snap_done) begin
                prev_snap  <= cur_snap;
                stable_cnt <= cnt_next;
            end
            if (accept) begin
                debounced <= cur_snap;
                key_down  <= (cur_snap != 16'h0000);
            end
            if (press_event) begin
                key_code <= hot_idx;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_SCANS=3 (one full scan = 16 cycles). A keypad model drives the
// columns from a 16-bit pressed mask; expected key codes go into a queue and
// are matched against every key_valid pulse by a monitor.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          vectors;
    int          miscompares;
    int          cyc;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release, used to align stimulus with the scan.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad model: a pressed key shorts its column to its row when driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check(tag, 16'(exp_q.size()), 16'd0);
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_pulse", {15'd0, key_valid}, 16'd0);
            else                   check("pulse_code", {12'd0, key_code}, {12'd0, exp_q.pop_front()});
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] er;
        vectors     = 0;
        miscompares = 0;
        pressed     = 16'h0000;
        rst         = 1'b1;

        // Reset and row stepping
        tick(5);
        check("rst_row", {12'd0, row}, 16'h000E);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_down", {15'd0, key_down}, 16'd0);
        check("rst_code", {12'd0, key_code}, 16'd0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            er = ~(4'b0001 << ((k / 4) % 4));
            check("row_step", {12'd0, row}, {12'd0, er});
        end

        // Single key (2,1)
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        tick(160);
        check("k9_drained", 16'(exp_q.size()), 16'd0);
        check("k9_code", {12'd0, key_code}, 16'h0009);
        check("k9_down", {15'd0, key_down}, 16'd1);
        pressed = 16'h0000;
        tick(16);
        check("k9_release_held", {15'd0, key_down}, 16'd1);
        tick(84);
        check("k9_release_down", {15'd0, key_down}, 16'd0);
        check("k9_release_code", {12'd0, key_code}, 16'h0009);

        // Bouncing key (0,3)
        for (int i = 0; i < 48; i++) begin
            pressed[3] = (((i / 5) % 2) == 0);
            tick(1);
        end
        check("bounce_down", {15'd0, key_down}, 16'd0);
        pressed[3] = 1'b1;
        exp_q.push_back(4'h3);
        wait_drain("bounce_drain", 100);
        tick(20);
        check("bounce_code", {12'd0, key_code}, 16'h0003);
        check("bounce_down_after", {15'd0, key_down}, 16'd1);
        pressed = 16'h0000;
        tick(100);
        check("bounce_release", {15'd0, key_down}, 16'd0);

        // Rollover (0,0) -> (0,0)+(1,1) -> (1,1)
        pressed[0] = 1'b1;
        exp_q.push_back(4'h0);
        wait_drain("roll_drain", 100);
        pressed[5] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("roll_add_down", {15'd0, key_down}, 16'd1);
        end
        pressed[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("roll_rel_down", {15'd0, key_down}, 16'd1);
        end
        check("roll_code", {12'd0, key_code}, 16'h0000);
        pressed = 16'h0000;
        tick(100);
        check("roll_release", {15'd0, key_down}, 16'd0);

        // Two keys (1,0) and (3,3) together, then (3,3) alone
        pressed[4]  = 1'b1;
        pressed[15] = 1'b1;
        tick(128);
        check("multi_down", {15'd0, key_down}, 16'd1);
        check("multi_code", {12'd0, key_code}, 16'h0000);
        pressed = 16'h0000;
        tick(100);
        check("multi_release", {15'd0, key_down}, 16'd0);
        pressed[15] = 1'b1;
        exp_q.push_back(4'hF);
        wait_drain("kf_drain", 100);
        tick(5);
        check("kf_code", {12'd0, key_code}, 16'h000F);
        check("kf_down", {15'd0, key_down}, 16'd1);
        pressed = 16'h0000;
        tick(100);
        check("kf_release", {15'd0, key_down}, 16'd0);

        // Reset while the press of (1,2) has seen two identical scans
        for (int i = 0; i < 16 && (cyc % 16) != 0; i++) tick(1);
        pressed[6] = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(3);
        check("mid_rst_row", {12'd0, row}, 16'h000E);
        check("mid_rst_valid", {15'd0, key_valid}, 16'd0);
        check("mid_rst_down", {15'd0, key_down}, 16'd0);
        check("mid_rst_code", {12'd0, key_code}, 16'd0);
        rst = 1'b0;
        exp_q.push_back(4'h6);
        tick(48);
        check("post_rst_no_early", 16'(exp_q.size()), 16'd1);
        check("post_rst_down_low", {15'd0, key_down}, 16'd0);
        tick(2);
        check("post_rst_drained", 16'(exp_q.size()), 16'd0);
        check("post_rst_down", {15'd0, key_down}, 16'd1);
        check("post_rst_code", {12'd0, key_code}, 16'h0006);
        pressed = 16'h0000;
        tick(100);
        check("final_release", {15'd0, key_down}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
